wf_pixel_loader: RTL and testbench
==================================

// Module: wf_pixel_loader
// PURPOSE
//  Upstream feeder for the 8x8 RGB dot-matrix pixel RAM (64x16, {1'b0,R5,G5,B5}).
//  Receives pixel writes from the CPU over a 3-wire serial link (WF_CPU pins) and
//  queues them in a small FIFO. Writes them into the pixel RAM write port only
//  during the idle window between the driver's scan_done and its next scan_en.
//  Replaces the free-running counter/random fill in the top level.
// PARAMETERS
//  FIFO_DEPTH  8   entries of {fill,addr[5:0],pixel[14:0]}, power of 2, >=2
//  SYNC_STAGES 2   flops on each async serial input
// PORTS
//  clk            in   1   12MHz core clock (SB_HFOSC)
//  reset          in   1   asynchronous, active-high; clears all state
//  ser_sck        in   1   async serial clock from CPU; data sampled on rising edge
//  ser_din        in   1   async serial data, MSB first
//  ser_cs_n       in   1   async frame select, active low
//  scan_en        in   1   1-clk pulse: driver starts a row scan (closes window)
//  scan_done      in   1   1-clk pulse: driver finished a row scan (opens window)
//  ram_wr_en      out  1   pixel RAM write strobe, registered
//  ram_wr_addr    out  6   {row[2:0],col[2:0]}, registered
//  ram_wr_pixels  out  16  bit15 always 0, registered
//  busy           out  1   FIFO non-empty or fill in progress
//  overflow       out  1   sticky: a word was dropped on full FIFO
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; window closed; rx state IDLE.
//  Input sync: SYNC_STAGES flops per input; sck rise = sync'd 0->1. ser_sck <= clk/8.
//  Serial frame (cs_n low): byte0 = CMD {mode[1:0],addr[5:0]}, then 16-bit words.
//   mode 2'b00 WRITE: each word pushes {0,addr,word[14:0]}; addr += 1, 63 wraps to 0.
//   mode 2'b01 FILL : first word pushes {1,6'd0,word[14:0]}; later words ignored.
//   mode 2'b1x      : frame ignored, nothing pushed.
//  Rx FSM: IDLE -(cs_n fall)-> CMD -(8 bits)-> DATA -(16 bits: push, stay)-> DATA.
//   cs_n fall also clears bit counter and overflow.
//   cs_n high in any state -> IDLE; partial byte/word discarded, never pushed.
//   cs_n fall while not IDLE (glitch) -> restart at CMD.
//  FIFO: push on word complete; if full, word dropped and overflow<=1.
//   Push and pop in same cycle legal at any fill level (incl. full).
//  Window: window<=0 on scan_en; window<=1 on scan_done.
//   Both in same cycle: scan_en wins (closed).
//  Writer FSM: WIDLE / WRITE / FILL.
//   WIDLE: window && !empty -> pop.
//    Next cycle: ram_wr_en=1 with popped addr/pixel (pop-to-write latency 1).
//    Fill entry -> FILL.
//   WRITE: at most one RAM write per clk, back-to-back while window && !empty.
//   FILL: writes pixel to addr 0..63 ascending, one per clk while window open.
//    Window close pauses with counter held; resumes at same addr next window.
//    Exits to WIDLE after addr 63 written.
//  ram_wr_en deasserts the cycle after the window closes; no write ever issued
//   while window=0. A write is never issued twice.
//  busy = !empty || state==FILL. overflow holds until next cs_n fall or reset.
//  Reset mid-frame/mid-fill: immediate clear; no RAM write after reset asserts.
// STRUCTURE
//  Package wf_pixel_pkg: PIX_W=16, ADDR_W=6, CMD_WRITE=2'b00, CMD_FILL=2'b01,
//   rx and writer state encodings.
//  Sub-module wf_sync_fifo (generic DEPTH/WIDTH, full/empty, simultaneous push/pop).
//  Serial receiver, window tracker and writer FSM live in this module.
// TESTING
//  1 WRITE frame CMD=0x05, words 0x7FFF,0x0421; then scan_done ->
//    RAM writes (5,0x7FFF),(6,0x0421) on consecutive clks; busy drops after.
//  2 CMD=0x3F, 2 words -> addrs 63 then 0 (wrap); bit15 of data written as 0.
//  3 FILL frame word 0x001F, scan_en 20 clks after scan_done ->
//    addrs 0..19 written; 2nd window resumes at 20; ends at 63; busy 0.
//  4 Push 10 words, no scan_done (FIFO_DEPTH=8) -> overflow=1 after 9th;
//    window then writes exactly the first 8; next cs_n fall clears overflow.
//  5 Raise cs_n after 9 data bits -> nothing pushed;
//    scan_en+scan_done same clk -> no writes.
//  6 Assert reset during FILL at addr 30 -> outputs 0 same cycle;
//    no writes until new frame.

Source files
------------

// File: rtl/wf_pixel_pkg.sv
// Shared widths, command codes, FSM encodings and FIFO entry layout
// for the dot-matrix pixel loader.
package wf_pixel_pkg;

  localparam int unsigned PIX_W  = 16;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = PIX_W - 1;
  localparam int unsigned BIT_W  = 4;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_FILL  = 2'b01;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_CMD  = 2'd1,
    RX_DATA = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_FILL  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic              fill;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pixel;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/wf_sync_fifo.sv
// Generic single-clock FIFO; push and pop may coincide at any fill level,
// including full (the popped slot is reused by the push).
module wf_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/wf_pixel_loader.sv
// Serial CPU link -> FIFO -> pixel RAM write port, writes confined to the
// idle window between the scan driver's scan_done and next scan_en.
module wf_pixel_loader
  import wf_pixel_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_sck,
  input  logic              ser_din,
  input  logic              ser_cs_n,
  input  logic              scan_en,
  input  logic              scan_done,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [PIX_W-1:0]  ram_wr_pixels,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------- input synchronisers and edge detect
  logic [SYNC_STAGES-1:0] sck_sync, din_sync, cs_sync;
  logic sck_prev, cs_prev;
  logic sck_s, din_s, cs_s;
  logic sck_rise_c, cs_fall_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '0;
      din_sync <= '0;
      cs_sync  <= '1;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], ser_sck};
      din_sync <= {din_sync[SYNC_STAGES-2:0], ser_din};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], ser_cs_n};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign din_s      = din_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign sck_rise_c = sck_s && !sck_prev;
  assign cs_fall_c  = cs_prev && !cs_s;

  // ---------------- serial receiver
  rx_state_e         rx_state, rx_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [PIX_W-3:0]  shift_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic              fill_seen_q;
  logic              bit_c, word_done_c, push_c;
  fifo_entry_t       entry_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_nxt;
  end

  always_comb begin
    rx_nxt = rx_state;
    if (cs_s)
      rx_nxt = RX_IDLE;
    else if (cs_fall_c)
      rx_nxt = RX_CMD;
    else if (sck_rise_c && rx_state == RX_CMD && bit_cnt == BIT_W'(7))
      rx_nxt = RX_DATA;
  end

  // A bit is only accepted inside an active frame with no restart pending.
  assign bit_c       = !cs_s && !cs_fall_c && sck_rise_c && rx_state != RX_IDLE;
  assign word_done_c = bit_c && rx_state == RX_DATA && bit_cnt == BIT_W'(15);
  assign push_c      = word_done_c &&
                       (mode_q == CMD_WRITE || (mode_q == CMD_FILL && !fill_seen_q));

  always_comb begin
    entry_c.fill  = (mode_q == CMD_FILL);
    entry_c.addr  = (mode_q == CMD_FILL) ? '0 : cur_addr_q;
    entry_c.pixel = {shift_q[DATA_W-2:0], din_s};
  end

  // ---------------- FIFO
  fifo_entry_t       head_c;
  logic [ENTRY_W-1:0] rd_data_c;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop_c, push_acc_c;
  logic [CNT_W-1:0]  cnt_nxt_c;

  wf_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push_c),
    .pop       (pop_c),
    .wr_data   (entry_c),
    .rd_data_c (rd_data_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_c     = fifo_entry_t'(rd_data_c);
  assign push_acc_c = push_c && (!fifo_full || pop_c);
  assign cnt_nxt_c  = fifo_count + CNT_W'(push_acc_c) - CNT_W'(pop_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      mode_q      <= '0;
      cur_addr_q  <= '0;
      fill_seen_q <= 1'b0;
      overflow    <= 1'b0;
    end else if (cs_fall_c) begin
      bit_cnt     <= '0;
      fill_seen_q <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (bit_c) begin
        shift_q <= {shift_q[PIX_W-4:0], din_s};
        if (rx_state == RX_CMD && bit_cnt == BIT_W'(7)) begin
          {mode_q, cur_addr_q} <= {shift_q[6:0], din_s};
          bit_cnt <= '0;
        end else if (word_done_c) begin
          bit_cnt <= '0;
          if (mode_q == CMD_WRITE) cur_addr_q  <= cur_addr_q + ADDR_W'(1);
          if (mode_q == CMD_FILL)  fill_seen_q <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
      if (push_c && fifo_full && !pop_c) overflow <= 1'b1;
    end
  end

  // ---------------- write window and RAM writer
  logic              window, window_c;
  wr_state_e         wr_state, wr_nxt;
  logic [ADDR_W-1:0] fill_cnt, fill_cnt_nxt;
  logic [DATA_W-1:0] fill_pix, fill_pix_nxt;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [PIX_W-1:0]  wr_pix_nxt;

  // Decisions use the window as it will be after this edge, so a write never
  // lands in a cycle where the window reads closed.
  assign window_c = scan_en ? 1'b0 : (scan_done ? 1'b1 : window);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_state <= WR_IDLE;
    else       wr_state <= wr_nxt;
  end

  always_comb begin
    wr_nxt       = wr_state;
    pop_c        = 1'b0;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = ram_wr_addr;
    wr_pix_nxt   = ram_wr_pixels;
    fill_cnt_nxt = fill_cnt;
    fill_pix_nxt = fill_pix;
    unique case (wr_state)
      WR_IDLE, WR_WRITE: begin
        wr_nxt = WR_IDLE;
        if (window_c && !fifo_empty) begin
          pop_c      = 1'b1;
          wr_en_nxt  = 1'b1;
          wr_pix_nxt = {1'b0, head_c.pixel};
          if (head_c.fill) begin
            wr_addr_nxt  = '0;
            fill_pix_nxt = head_c.pixel;
            fill_cnt_nxt = ADDR_W'(1);
            wr_nxt       = WR_FILL;
          end else begin
            wr_addr_nxt = head_c.addr;
            wr_nxt      = WR_WRITE;
          end
        end
      end
      WR_FILL: begin
        if (window_c) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = fill_cnt;
          wr_pix_nxt  = {1'b0, fill_pix};
          if (fill_cnt == '1) wr_nxt = WR_IDLE;
          else                fill_cnt_nxt = fill_cnt + ADDR_W'(1);
        end
      end
      default: wr_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window        <= 1'b0;
      ram_wr_en     <= 1'b0;
      ram_wr_addr   <= '0;
      ram_wr_pixels <= '0;
      fill_cnt      <= '0;
      fill_pix      <= '0;
      busy          <= 1'b0;
    end else begin
      window        <= window_c;
      ram_wr_en     <= wr_en_nxt;
      ram_wr_addr   <= wr_addr_nxt;
      ram_wr_pixels <= wr_pix_nxt;
      fill_cnt      <= fill_cnt_nxt;
      fill_pix      <= fill_pix_nxt;
      busy          <= (cnt_nxt_c != '0) || (wr_nxt == WR_FILL);
    end
  end

endmodule

// File: tb/tb_wf_pixel_loader.sv
// Scoreboard bench for wf_pixel_loader: serial frames in, RAM writes checked
// in order against expectations queued as frames are sent.
module tb_wf_pixel_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ser_sck = 1'b0;
  logic        ser_din = 1'b0;
  logic        ser_cs_n = 1'b1;
  logic        scan_en = 1'b0;
  logic        scan_done = 1'b0;
  logic        ram_wr_en;
  logic [5:0]  ram_wr_addr;
  logic [15:0] ram_wr_pixels;
  logic        busy;
  logic        overflow;

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] pix;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   wr_count = 0;
  int   base;
  logic tb_win;
  logic hit;

  wf_pixel_loader dut (
    .clk           (clk),
    .reset         (reset),
    .ser_sck       (ser_sck),
    .ser_din       (ser_din),
    .ser_cs_n      (ser_cs_n),
    .scan_en       (scan_en),
    .scan_done     (scan_done),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_pixels (ram_wr_pixels),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent window model: closed by scan_en, opened by scan_done.
  always @(posedge clk or posedge reset) begin
    if (reset)          tb_win <= 1'b0;
    else if (scan_en)   tb_win <= 1'b0;
    else if (scan_done) tb_win <= 1'b1;
  end

  always @(negedge clk) begin
    if (!reset && ram_wr_en) begin
      exp_t e;
      wr_count++;
      chk("wr_in_window", 32'(tb_win), 32'd1);
      if (sb.size() == 0) begin
        chk("spurious_wr", 32'(ram_wr_en), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(ram_wr_addr), 32'(e.addr));
        chk("wr_pix", 32'(ram_wr_pixels), 32'(e.pix));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ser_din = v[i];
      tick(4);
      ser_sck = 1'b1;
      tick(4);
      ser_sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    ser_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_end();
    tick(4);
    ser_cs_n = 1'b1;
    tick(4);
  endtask

  task automatic pulse(input logic en, input logic done);
    scan_en   = en;
    scan_done = done;
    tick(1);
    scan_en   = 1'b0;
    scan_done = 1'b0;
  endtask

  task automatic push_exp(input logic [5:0] a, input logic [15:0] p);
    exp_t e;
    e.addr = a;
    e.pix  = {1'b0, p[14:0]};
    sb.push_back(e);
  endtask

  initial begin
    tick(3);
    chk("rst_we", 32'(ram_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(2);
    chk("rst_addr", 32'(ram_wr_addr), 32'd0);
    chk("rst_pix", 32'(ram_wr_pixels), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // 1: write frame, drained back-to-back when the window opens
    cs_start();
    send_bits(16'h0005, 8);
    send_bits(16'h7FFF, 16); push_exp(6'd5, 16'h7FFF);
    send_bits(16'h0421, 16); push_exp(6'd6, 16'h0421);
    cs_end();
    chk("t1_busy_q", 32'(busy), 32'd1);
    chk("t1_no_wr", 32'(wr_count), 32'd0);
    pulse(1'b0, 1'b1);
    chk("t1_we_a", 32'(ram_wr_en), 32'd1);
    tick(1);
    chk("t1_we_b", 32'(ram_wr_en), 32'd1);
    tick(1);
    chk("t1_we_off", 32'(ram_wr_en), 32'd0);
    chk("t1_busy_off", 32'(busy), 32'd0);
    pulse(1'b1, 1'b0);

    // 2: address wrap and bit15 masking
    cs_start();
    send_bits(16'h003F, 8);
    send_bits(16'hFFFF, 16); push_exp(6'd63, 16'hFFFF);
    send_bits(16'h8001, 16); push_exp(6'd0, 16'h8001);
    cs_end();
    pulse(1'b0, 1'b1);
    tick(5);
    chk("t2_drained", 32'(sb.size()), 32'd0);
    pulse(1'b1, 1'b0);

    // 3: fill across two windows, second word ignored
    cs_start();
    send_bits(16'h0040, 8);
    send_bits(16'h001F, 16);
    send_bits(16'h1234, 16);
    cs_end();
    for (int a = 0; a < 64; a++) push_exp(6'(a), 16'h001F);
    base = wr_count;
    pulse(1'b0, 1'b1);
    tick(19);
    pulse(1'b1, 1'b0);
    chk("t3_win1", 32'(wr_count - base), 32'd20);
    chk("t3_we_closed", 32'(ram_wr_en), 32'd0);
    chk("t3_busy_paused", 32'(busy), 32'd1);
    tick(10);
    chk("t3_hold", 32'(wr_count - base), 32'd20);
    pulse(1'b0, 1'b1);
    tick(50);
    chk("t3_total", 32'(wr_count - base), 32'd64);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_drained", 32'(sb.size()), 32'd0);
    pulse(1'b1, 1'b0);

    // 4: overflow on a full FIFO, then cleared by the next frame start
    cs_start();
    send_bits(16'h0000, 8);
    for (int i = 0; i < 10; i++) begin
      send_bits(16'h0100 + 16'(i), 16);
      if (i < 8) push_exp(6'(i), 16'h0100 + 16'(i));
      if (i == 7) chk("t4_ovf_8", 32'(overflow), 32'd0);
      if (i == 8) chk("t4_ovf_9", 32'(overflow), 32'd1);
    end
    cs_end();
    chk("t4_ovf_hold", 32'(overflow), 32'd1);
    base = wr_count;
    pulse(1'b0, 1'b1);
    tick(12);
    chk("t4_writes", 32'(wr_count - base), 32'd8);
    chk("t4_drained", 32'(sb.size()), 32'd0);
    ser_cs_n = 1'b0;
    tick(4);
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    ser_cs_n = 1'b1;
    tick(4);
    pulse(1'b1, 1'b0);

    // 5: partial word discarded; simultaneous scan_en/scan_done keeps window shut
    cs_start();
    send_bits(16'h0010, 8);
    send_bits(16'h01FF, 9);
    cs_end();
    chk("t5_partial", 32'(busy), 32'd0);
    cs_start();
    send_bits(16'h0020, 8);
    send_bits(16'h2AAA, 16); push_exp(6'd32, 16'h2AAA);
    cs_end();
    base = wr_count;
    pulse(1'b1, 1'b1);
    tick(10);
    chk("t5_both", 32'(wr_count - base), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    pulse(1'b0, 1'b1);
    tick(4);
    chk("t5_drained", 32'(sb.size()), 32'd0);
    pulse(1'b1, 1'b0);

    // 6: reset during a fill at address 30
    cs_start();
    send_bits(16'h0040, 8);
    send_bits(16'h7C00, 16);
    cs_end();
    for (int a = 0; a <= 30; a++) push_exp(6'(a), 16'h7C00);
    pulse(1'b0, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ram_wr_en && ram_wr_addr == 6'd30) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    chk("t6_reach30", 32'(hit), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t6_we", 32'(ram_wr_en), 32'd0);
    chk("t6_addr", 32'(ram_wr_addr), 32'd0);
    chk("t6_pix", 32'(ram_wr_pixels), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    base = wr_count;
    pulse(1'b0, 1'b1);
    tick(20);
    chk("t6_no_wr", 32'(wr_count - base), 32'd0);
    chk("t6_busy_after", 32'(busy), 32'd0);
    chk("t6_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
